// File: rtl/segment_arb_pkg.sv
// Shared constants and types for the segment arbiter.
//   MODE_FIXED / MODE_RR : arbitration mode encodings
//   MAX_MASTERS          : largest supported requester count
//   CNT_W                : tenure counter width
package segment_arb_pkg;

   localparam int MODE_FIXED  = 0;
   localparam int MODE_RR     = 1;
   localparam int MAX_MASTERS = 32;
   localparam int CNT_W       = 16;

   typedef enum logic {
      ST_IDLE  = 1'b0,
      ST_OWNED = 1'b1
   } arb_state_e;

endpackage

// File: rtl/segment_arb_pick.sv
// Rotating priority encoder for the segment arbiter.
//   req    : request vector
//   base   : index of the previous winner (round-robin pointer)
//   mode   : 0 = search from index 0, 1 = search from base+1 with wrap
//   winner : index of the first request found
//   found  : at least one request is set
module segment_arb_pick #(
   parameter int  MASTERS = 2,
   localparam int IDW     = (MASTERS > 1) ? $clog2(MASTERS) : 1
) (
   input  logic [MASTERS-1:0] req,
   input  logic [IDW-1:0]     base,
   input  logic               mode,
   output logic [IDW-1:0]     winner,
   output logic               found
);

   logic [2*MASTERS-1:0] dbl;
   logic [MASTERS-1:0]   rot;
   int                   start;
   int                   pos;

   always_comb begin
      start = 0;
      if (mode) begin
         start = int'(base) + 1;
         if (start >= MASTERS) start = 0;
      end
      // Shifting the doubled vector right by start gives a rotation, so a
      // plain lowest-index search walks start, start+1, ... with wrap.
      dbl = {req, req} >> start;
      rot = dbl[MASTERS-1:0];
      found = 1'b0;
      pos   = 0;
      for (int i = MASTERS - 1; i >= 0; i--) begin
         if (rot[i]) begin
            found = 1'b1;
            pos   = i;
         end
      end
      pos = pos + start;
      if (pos >= MASTERS) pos = pos - MASTERS;
      winner = IDW'(pos);
   end

endmodule

// File: rtl/segment_arbiter_rr.sv
// Bus-segment arbiter: fixed-priority or round-robin grant with hold,
// bounded tenure and lock override.
//   hclock       : segment clock
//   hreset       : asynchronous active-high reset
//   bus_requests : per-master request level
//   bus_lock     : per-master lock (only the owner's bit matters)
//   bus_grants   : one-hot-or-zero grant, masked by live request
//   grant_valid  : any grant active
//   grant_id     : owner index, held while no grant is active
//   hold_expired : one-cycle pulse with the first grant after a pre-emption
//
// state    | meaning
// ST_IDLE  | no owner, arbitrate every cycle
// ST_OWNED | one master owns the segment, tenure counter running
module segment_arbiter_rr
   import segment_arb_pkg::*;
#(
   parameter int  MASTERS  = 2,
   parameter int  MODE     = MODE_FIXED,
   parameter int  MAX_HOLD = 16,
   localparam int IDW      = (MASTERS > 1) ? $clog2(MASTERS) : 1
) (
   input  logic               hclock,
   input  logic               hreset,
   input  logic [MASTERS-1:0] bus_requests,
   input  logic [MASTERS-1:0] bus_lock,
   output logic [MASTERS-1:0] bus_grants,
   output logic               grant_valid,
   output logic [IDW-1:0]     grant_id,
   output logic               hold_expired
);

   localparam bit               HOLD_EN  = (MAX_HOLD > 0);
   localparam logic [CNT_W-1:0] HOLD_LIM = HOLD_EN ? CNT_W'(MAX_HOLD - 1) : '0;
   localparam logic [IDW-1:0]   LAST_RST = IDW'(MASTERS - 1);
   localparam logic             MODE_SEL = (MODE == MODE_RR);

   logic [MASTERS-1:0] own, own_nxt;
   logic [IDW-1:0]     last, last_nxt, gid_nxt;
   logic [CNT_W-1:0]   cnt, cnt_nxt;
   logic               exp_nxt;
   arb_state_e         state;
   logic               owner_req, owner_lock, others, preempt, rearb;
   logic [IDW-1:0]     win_id;
   logic               win_found;

   segment_arb_pick #(.MASTERS(MASTERS)) u_pick (
      .req    (bus_requests),
      .base   (last),
      .mode   (MODE_SEL),
      .winner (win_id),
      .found  (win_found)
   );

   always_comb begin
      state      = (own == '0) ? ST_IDLE : ST_OWNED;
      owner_req  = |(own & bus_requests);
      owner_lock = |(own & bus_lock);
      others     = |(bus_requests & ~own);
      preempt    = 1'b0;
      if (HOLD_EN && state == ST_OWNED && owner_req && !owner_lock &&
          others && cnt >= HOLD_LIM)
         preempt = 1'b1;
      rearb = (state == ST_IDLE) || !owner_req || preempt;
   end

   always_comb begin
      own_nxt  = own;
      gid_nxt  = grant_id;
      last_nxt = last;
      cnt_nxt  = cnt;
      exp_nxt  = 1'b0;
      if (rearb) begin
         cnt_nxt = '0;
         if (win_found) begin
            for (int i = 0; i < MASTERS; i++)
               own_nxt[i] = (win_id == IDW'(i));
            gid_nxt  = win_id;
            last_nxt = win_id;
            exp_nxt  = preempt;
         end else begin
            own_nxt = '0;
         end
      end else if (cnt != '1) begin
         cnt_nxt = cnt + CNT_W'(1);
      end
   end

   always_ff @(posedge hclock or posedge hreset) begin
      if (hreset) begin
         own          <= '0;
         grant_id     <= '0;
         last         <= LAST_RST;
         cnt          <= '0;
         hold_expired <= 1'b0;
      end else begin
         own          <= own_nxt;
         grant_id     <= gid_nxt;
         last         <= last_nxt;
         cnt          <= cnt_nxt;
         hold_expired <= exp_nxt;
      end
   end

   // Masking with the live request drops a grant in the same cycle.
   assign bus_grants  = own & bus_requests;
   assign grant_valid = |bus_grants;

endmodule
